// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and coordinate type for the vga_clk domain.
// Renderer stages import coord_t so every coordinate bus has one width.
package vga_timing_pkg;

   // 640x480@60 Hz defaults (25 MHz pixel clock)
   localparam int unsigned H_VISIBLE_DEF = 640;
   localparam int unsigned H_FP_DEF      = 16;
   localparam int unsigned H_SYNC_DEF    = 96;
   localparam int unsigned H_BP_DEF      = 48;
   localparam int unsigned V_VISIBLE_DEF = 480;
   localparam int unsigned V_FP_DEF      = 10;
   localparam int unsigned V_SYNC_DEF    = 2;
   localparam int unsigned V_BP_DEF      = 33;

   localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int unsigned COORD_W    = 10;
   localparam int unsigned COORD_SPAN = 1 << COORD_W;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [7:0]         frame_cnt_t;

   // Half-open window test: lo <= pos < hi
   function automatic logic in_window(input coord_t pos, input coord_t lo, input coord_t hi);
      return (pos >= lo) && (pos < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis position counter. `count` is the position being decoded
// this cycle: a synchronous clear forces it to 0 so the clear edge decodes
// (0) and the register then advances from 0 as on any other edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL = H_TOTAL
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   inc,
   input  logic   clr,
   output coord_t count,
   output logic   wrap
);

   if (TOTAL < 2 || TOTAL > COORD_SPAN) begin : g_bad_total
      $error("vga_axis_counter: TOTAL must be in 2..1024");
   end

   localparam coord_t LAST = coord_t'(TOTAL - 1);

   coord_t cnt_q;
   coord_t cnt_d;
   coord_t cur;

   // Effective position, wrap detect and next count
   always_comb begin
      cur   = clr ? '0 : cnt_q;
      wrap  = inc && (cur == LAST);
      cnt_d = cur;
      if (inc) begin
         cnt_d = wrap ? '0 : coord_t'(cur + coord_t'(1));
      end
   end

   // Position register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count = cur;

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator. All outputs are registered from
// the decode of the current (hc, vc), so they lag the counters by one cycle
// and are mutually aligned.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
   parameter int unsigned H_FP      = H_FP_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BP      = H_BP_DEF,
   parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
   parameter int unsigned V_FP      = V_FP_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BP      = V_BP_DEF
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       restart,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_tick,
   output logic [7:0] frame_count
);

   localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

   if (H_TOT > COORD_SPAN || V_TOT > COORD_SPAN) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
   localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   coord_t hc;
   coord_t vc;
   logic   h_wrap;
   logic   v_wrap_unused;

   vga_axis_counter #(.TOTAL(H_TOT)) u_hcount (
      .clk   (vga_clk),
      .rst_n (reset_n),
      .inc   (1'b1),
      .clr   (restart),
      .count (hc),
      .wrap  (h_wrap)
   );

   vga_axis_counter #(.TOTAL(V_TOT)) u_vcount (
      .clk   (vga_clk),
      .rst_n (reset_n),
      .inc   (h_wrap),
      .clr   (restart),
      .count (vc),
      .wrap  (v_wrap_unused)
   );

   coord_t     x_q, x_d;
   coord_t     y_q, y_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       tick_q, tick_d;
   frame_cnt_t fc_q, fc_d;

   // Decode current raster position into next output values
   always_comb begin
      x_d     = hc;
      y_d     = vc;
      blank_d = (hc < H_VIS_C) && (vc < V_VIS_C);
      hs_d    = ~in_window(hc, HS_START, HS_END);
      vs_d    = ~in_window(vc, VS_START, VS_END);
      // hc/vc already read as 0 under restart; the explicit term keeps the
      // tick suppressed even for a zero-height visible area
      tick_d  = ~restart && (hc == '0) && (vc == V_VIS_C);
      fc_d    = fc_q;
      if (restart) begin
         fc_d = '0;
      end else if (tick_d) begin
         fc_d = fc_q + 8'd1;
      end
   end

   // Output registers; reset shows an idle, blanked raster at (0,0)
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         blank_q <= 1'b0;
         tick_q  <= 1'b0;
         fc_q    <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
         fc_q    <= fc_d;
      end
   end

   assign DrawX       = x_q;
   assign DrawY       = y_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign frame_tick  = tick_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a driver picks restart each cycle and pushes the expected
// registered outputs from a frame-position model; a monitor pops and compares.
// Two instances: default 640x480 geometry (first lines only) and a tiny one
// that completes many frames quickly.
module tb_vga_timing_gen;

   typedef struct packed {
      int unsigned hv, hfp, hs, hbp, vv, vfp, vs, vbp;
   } geo_t;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       blank;
      logic       tick;
      logic [7:0] fc;
   } out_t;

   localparam int unsigned S_HV = 8, S_HFP = 2, S_HS = 3, S_HBP = 3;
   localparam int unsigned S_VV = 5, S_VFP = 2, S_VS = 2, S_VBP = 3;
   localparam int unsigned S_FRAME = (S_HV + S_HFP + S_HS + S_HBP) * (S_VV + S_VFP + S_VS + S_VBP);

   localparam geo_t GD = '{640, 16, 96, 48, 480, 10, 2, 33};
   localparam geo_t GS = '{S_HV, S_HFP, S_HS, S_HBP, S_VV, S_VFP, S_VS, S_VBP};
   localparam out_t RST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0, tick: 1'b0, fc: 8'd0};

   logic       vga_clk = 1'b0;
   logic       reset_n;
   logic       restart;
   logic [9:0] dx_d, dy_d, dx_s, dy_s;
   logic       hs_d, vs_d, bl_d, tk_d, hs_s, vs_s, bl_s, tk_s;
   logic [7:0] fc_d, fc_s;

   vga_timing_gen dut_d (
      .vga_clk(vga_clk), .reset_n(reset_n), .restart(restart),
      .DrawX(dx_d), .DrawY(dy_d), .hs(hs_d), .vs(vs_d), .blank(bl_d),
      .frame_tick(tk_d), .frame_count(fc_d)
   );

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
      .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP)
   ) dut_s (
      .vga_clk(vga_clk), .reset_n(reset_n), .restart(restart),
      .DrawX(dx_s), .DrawY(dy_s), .hs(hs_s), .vs(vs_s), .blank(bl_s),
      .frame_tick(tk_s), .frame_count(fc_s)
   );

   always #5 vga_clk = ~vga_clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   out_t exp_d_q[$];
   out_t exp_s_q[$];

   int unsigned p_d = 0, f_d = 0, p_s = 0, f_s = 0;
   int unsigned rs_chance = 0;
   bit          rs_tick_s = 1'b0;
   bit          stop      = 1'b0;
   bit          wrap_phase = 1'b0;
   int unsigned wrap_ticks = 0;

   function automatic void check_out(input string name, input out_t a, input out_t e);
      n_checks++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b blank=%b tick=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b blank=%b tick=%b fc=%0d",
                  name, a.x, a.y, a.hs, a.vs, a.blank, a.tick, a.fc,
                  e.x, e.y, e.hs, e.vs, e.blank, e.tick, e.fc);
      end
   endfunction

   function automatic void check_val(input string name, input int a, input int e);
      n_checks++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, a, e);
      end
   endfunction

   // Expected outputs after one edge, from the linear position p within the frame
   function automatic out_t model_step(input geo_t g, input bit rs,
                                       inout int unsigned p, inout int unsigned fc);
      int unsigned ht, vt, x, y;
      bit          tk;
      out_t        o;
      ht = g.hv + g.hfp + g.hs + g.hbp;
      vt = g.vv + g.vfp + g.vs + g.vbp;
      if (rs) p = 0;
      x  = p % ht;
      y  = p / ht;
      tk = !rs && (p == g.vv * ht);
      if (rs)      fc = 0;
      else if (tk) fc = (fc + 1) % 256;
      o.x     = x[9:0];
      o.y     = y[9:0];
      o.blank = (x < g.hv) && (y < g.vv);
      o.hs    = !((x >= g.hv + g.hfp) && (x < g.hv + g.hfp + g.hs));
      o.vs    = !((y >= g.vv + g.vfp) && (y < g.vv + g.vfp + g.vs));
      o.tick  = tk;
      o.fc    = fc[7:0];
      p = (p + 1) % (ht * vt);
      return o;
   endfunction

   // Driver: choose restart for the coming edge and queue expectations
   initial begin : driver
      bit rs;
      restart = 1'b0;
      forever begin
         @(negedge vga_clk);
         if (!reset_n || stop) begin
            restart = 1'b0;
            if (!reset_n) begin
               p_d = 0; f_d = 0; p_s = 0; f_s = 0;
            end
         end else begin
            rs = 1'b0;
            if (rs_chance != 0 && $urandom_range(rs_chance - 1) == 0) rs = 1'b1;
            if (rs_tick_s && p_s == S_VV * (S_HV + S_HFP + S_HS + S_HBP)) rs = 1'b1;
            restart = rs;
            exp_d_q.push_back(model_step(GD, rs, p_d, f_d));
            exp_s_q.push_back(model_step(GS, rs, p_s, f_s));
         end
      end
   end

   // Monitor: compare every registered output set after each edge
   initial begin : monitor
      out_t e;
      forever begin
         @(posedge vga_clk);
         #1;
         if (exp_d_q.size() != 0) begin
            e = exp_d_q.pop_front();
            check_out("raster_640", {dx_d, dy_d, hs_d, vs_d, bl_d, tk_d, fc_d}, e);
         end
         if (exp_s_q.size() != 0) begin
            e = exp_s_q.pop_front();
            check_out("raster_small", {dx_s, dy_s, hs_s, vs_s, bl_s, tk_s, fc_s}, e);
         end
         if (reset_n && tk_s) begin
            check_val("tick_pos_x", int'(dx_s), 0);
            check_val("tick_pos_y", int'(dy_s), int'(S_VV));
            if (wrap_phase) begin
               wrap_ticks++;
               if (wrap_ticks == 256) check_val("fc_wrap_256", int'(fc_s), 0);
            end
         end
      end
   end

   initial begin : main
      reset_n = 1'b0;
      repeat (3) @(posedge vga_clk);
      #3 reset_n = 1'b1;

      // Edge k after release shows DrawX = k-1; stop inside the hs pulse
      repeat (701) @(posedge vga_clk);
      #2;
      check_val("x_at_700", int'(dx_d), 700);
      check_val("hs_low_at_700", int'(hs_d), 0);
      #1 reset_n = 1'b0;
      #1;
      check_out("async_reset_640", {dx_d, dy_d, hs_d, vs_d, bl_d, tk_d, fc_d}, RST);
      check_out("async_reset_small", {dx_s, dy_s, hs_s, vs_s, bl_s, tk_s, fc_s}, RST);
      repeat (2) @(posedge vga_clk);
      #3 reset_n = 1'b1;

      // Random restarts over several small frames
      rs_chance = 12;
      repeat (8 * S_FRAME) @(posedge vga_clk);
      rs_chance = 0;

      // Restart coincident with the small raster's tick position
      rs_tick_s = 1'b1;
      repeat (200) @(posedge vga_clk);
      rs_tick_s = 1'b0;

      // Free run long enough for frame_count to wrap past 255
      wrap_phase = 1'b1;
      repeat (256 * S_FRAME + 100) @(posedge vga_clk);
      wrap_phase = 1'b0;
      check_val("wrap_ticks_seen", int'(wrap_ticks >= 256), 1);

      stop = 1'b1;
      repeat (3) @(posedge vga_clk);
      #2;
      check_val("queue_drained", exp_d_q.size() + exp_s_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
